// File: rtl/riscp_pkg.sv
// Shared widths, ALU opcodes and the EX/MEM control payload.
package riscp_pkg;

  localparam int unsigned DW_DEFAULT   = 32;
  localparam int unsigned RW_DEFAULT   = 5;
  localparam int unsigned AOPW_DEFAULT = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  // Control bits carried from EX to MEM; all forced low in bubbles.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage.
module ex_alu
  import riscp_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned AOPW = AOPW_DEFAULT
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [AOPW-1:0] op,
  output logic [DW-1:0]   result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(DW);

  // Operation select; SLT compares as two's-complement and yields 0/1.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = DW'($signed(a) < $signed(b));
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[SHW-1:0];
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with ALU, branch resolution and a handshaked EX/MEM register.
module ex_mem_stage
  import riscp_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned RW   = RW_DEFAULT,
  parameter int unsigned AOPW = AOPW_DEFAULT
) (
  input  logic            clk,
  input  logic            res,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AOPW-1:0] iALUOp,
  input  logic            iRegDest,
  input  logic            iRegWrite,
  input  logic            iALUSrc,
  input  logic            iMemRead,
  input  logic            iMemWrite,
  input  logic            iMemToReg,
  input  logic            iBranch,
  input  logic [DW-1:0]   ioperand1,
  input  logic [DW-1:0]   ioperand2,
  input  logic [DW-1:0]   iextinst,
  input  logic [RW-1:0]   iregdest1,
  input  logic [RW-1:0]   iregdest2,
  input  logic [DW-1:0]   iNextInst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   oALUResult,
  output logic [DW-1:0]   oStoreData,
  output logic [RW-1:0]   oWriteReg,
  output logic            oRegWrite,
  output logic            oMemRead,
  output logic            oMemWrite,
  output logic            oMemToReg,
  output logic            oBranchTaken,
  output logic [DW-1:0]   oBranchTarget,
  output logic            oZero
);

  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   alu_q, alu_d;
  logic [DW-1:0]   store_q, store_d;
  logic [DW-1:0]   target_q, target_d;
  logic [RW-1:0]   wreg_q, wreg_d;
  ex_ctrl_t        ctrl_q, ctrl_d;
  logic            taken_q, taken_d;
  logic            zero_q, zero_d;

  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_res;
  logic            alu_zero;
  logic [DW-1:0]   br_target;
  logic            br_taken;
  ex_ctrl_t        ctrl_in;

  // No skid buffer: accept whenever the register is empty or being drained.
  assign in_ready = !out_valid_q || out_ready;

  assign alu_b     = iALUSrc ? iextinst : ioperand2;
  assign br_target = iNextInst + (iextinst << 2);
  assign br_taken  = iBranch && (ioperand1 == ioperand2);
  assign ctrl_in   = {iRegWrite, iMemRead, iMemWrite, iMemToReg};

  ex_alu #(
    .DW   (DW),
    .AOPW (AOPW)
  ) u_alu (
    .a      (ioperand1),
    .b      (alu_b),
    .op     (iALUOp),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Next-state of the EX/MEM register: load, bubble, or hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    store_d     = store_q;
    target_d    = target_q;
    wreg_d      = wreg_q;
    ctrl_d      = ctrl_q;
    taken_d     = taken_q;
    zero_d      = zero_q;
    if (in_ready) begin
      if (in_valid) begin
        out_valid_d = !flush;
        alu_d       = alu_res;
        store_d     = ioperand2;
        target_d    = br_target;
        wreg_d      = iRegDest ? iregdest2 : iregdest1;
        zero_d      = alu_zero;
        ctrl_d      = flush ? '0 : ctrl_in;
        taken_d     = !flush && br_taken;
      end else begin
        out_valid_d = 1'b0;
        ctrl_d      = '0;
        taken_d     = 1'b0;
      end
    end
  end

  // EX/MEM register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      store_q     <= '0;
      target_q    <= '0;
      wreg_q      <= '0;
      ctrl_q      <= '0;
      taken_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      store_q     <= store_d;
      target_q    <= target_d;
      wreg_q      <= wreg_d;
      ctrl_q      <= ctrl_d;
      taken_q     <= taken_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign oALUResult    = alu_q;
  assign oStoreData    = store_q;
  assign oBranchTarget = target_q;
  assign oWriteReg     = wreg_q;
  assign oRegWrite     = ctrl_q.reg_write;
  assign oMemRead      = ctrl_q.mem_read;
  assign oMemWrite     = ctrl_q.mem_write;
  assign oMemToReg     = ctrl_q.mem_to_reg;
  assign oBranchTaken  = taken_q;
  assign oZero         = zero_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver pushes expected entries, monitor pops on transfer.
module tb_ex_mem_stage;

  typedef struct {
    logic [2:0]  op;
    logic        regdest, regwrite, alusrc, memread, memwrite, memtoreg, branch;
    logic [31:0] op1, op2, ext, next;
    logic [4:0]  rd1, rd2;
  } bundle_t;

  typedef struct {
    logic [31:0] alu, store, target;
    logic [4:0]  wreg;
    logic        rw, mr, mw, m2r, taken, zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  iALUOp = '0;
  logic        iRegDest = 0, iRegWrite = 0, iALUSrc = 0, iMemRead = 0;
  logic        iMemWrite = 0, iMemToReg = 0, iBranch = 0;
  logic [31:0] ioperand1 = '0, ioperand2 = '0, iextinst = '0, iNextInst = '0;
  logic [4:0]  iregdest1 = '0, iregdest2 = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] oALUResult, oStoreData, oBranchTarget;
  logic [4:0]  oWriteReg;
  logic        oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchTaken, oZero;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  bit   mon_en  = 1'b0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .iALUOp(iALUOp), .iRegDest(iRegDest), .iRegWrite(iRegWrite), .iALUSrc(iALUSrc),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg), .iBranch(iBranch),
    .ioperand1(ioperand1), .ioperand2(ioperand2), .iextinst(iextinst),
    .iregdest1(iregdest1), .iregdest2(iregdest2), .iNextInst(iNextInst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .oALUResult(oALUResult), .oStoreData(oStoreData), .oWriteReg(oWriteReg),
    .oRegWrite(oRegWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oMemToReg(oMemToReg), .oBranchTaken(oBranchTaken), .oBranchTarget(oBranchTarget),
    .oZero(oZero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // Reference behaviour of one instruction, straight from the ISA description.
  function automatic exp_t model(input bundle_t b);
    exp_t        e;
    logic [31:0] bb;
    int          sa, sb_i;
    bb = b.alusrc ? b.ext : b.op2;
    sa = int'(b.op1);
    sb_i = int'(bb);
    case (b.op)
      3'd0: e.alu = b.op1 + bb;
      3'd1: e.alu = b.op1 - bb;
      3'd2: e.alu = b.op1 & bb;
      3'd3: e.alu = b.op1 | bb;
      3'd4: e.alu = (sa < sb_i) ? 32'd1 : 32'd0;
      3'd5: e.alu = b.op1 ^ bb;
      3'd6: e.alu = b.op1 << bb[4:0];
      default: e.alu = ~(b.op1 | bb);
    endcase
    e.zero   = (e.alu == 32'd0);
    e.store  = b.op2;
    e.target = b.next + b.ext * 32'd4;
    e.wreg   = b.regdest ? b.rd2 : b.rd1;
    e.rw     = b.regwrite;
    e.mr     = b.memread;
    e.mw     = b.memwrite;
    e.m2r    = b.memtoreg;
    e.taken  = b.branch && (b.op1 == b.op2);
    return e;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.op       = 3'($urandom_range(0, 7));
    b.regdest  = 1'($urandom);
    b.regwrite = 1'($urandom);
    b.alusrc   = 1'($urandom);
    b.memread  = 1'($urandom);
    b.memwrite = 1'($urandom);
    b.memtoreg = 1'($urandom);
    b.branch   = 1'($urandom);
    b.op1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    b.op2      = ($urandom_range(0, 2) == 0) ? b.op1 : $urandom;
    b.ext      = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
    b.next     = $urandom & 32'hFFFF_FFFC;
    b.rd1      = 5'($urandom);
    b.rd2      = 5'($urandom);
    return b;
  endfunction

  function automatic bundle_t zero_bundle();
    bundle_t b;
    b = rand_bundle();
    b.regdest = 0; b.regwrite = 0; b.alusrc = 0; b.memread = 0;
    b.memwrite = 0; b.memtoreg = 0; b.branch = 0;
    return b;
  endfunction

  task automatic apply(input bundle_t b);
    iALUOp = b.op; iRegDest = b.regdest; iRegWrite = b.regwrite; iALUSrc = b.alusrc;
    iMemRead = b.memread; iMemWrite = b.memwrite; iMemToReg = b.memtoreg; iBranch = b.branch;
    ioperand1 = b.op1; ioperand2 = b.op2; iextinst = b.ext; iNextInst = b.next;
    iregdest1 = b.rd1; iregdest2 = b.rd2;
  endtask

  // One cycle of stimulus; expected entry queued only if the bundle is really taken.
  task automatic cyc(input bundle_t b, input logic v, input logic fl, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    #2;
    apply(b);
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    #2;
    exp_rdy = (sb.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy && !fl) sb.push_back(model(b));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".alu"}, oALUResult, 32'd0);
    chk({tag, ".store"}, oStoreData, 32'd0);
    chk({tag, ".target"}, oBranchTarget, 32'd0);
    chk({tag, ".wreg"}, 32'(oWriteReg), 32'd0);
    chk({tag, ".ctrl"}, 32'({oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchTaken, oZero}), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Monitor: compares the presented entry each cycle and retires it on transfer.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
          chk("oALUResult", oALUResult, sb[0].alu);
          chk("oStoreData", oStoreData, sb[0].store);
          chk("oBranchTarget", oBranchTarget, sb[0].target);
          chk("oWriteReg", 32'(oWriteReg), 32'(sb[0].wreg));
          chk("ctrl", 32'({oRegWrite, oMemRead, oMemWrite, oMemToReg}),
              32'({sb[0].rw, sb[0].mr, sb[0].mw, sb[0].m2r}));
          chk("oBranchTaken", 32'(oBranchTaken), 32'(sb[0].taken));
          chk("oZero", 32'(oZero), 32'(sb[0].zero));
        end else if (!out_valid) begin
          chk("bubble_ctrl", 32'({oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranchTaken}), 32'd0);
        end
        #2;
        if (mon_en && out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bundle_t b;

    // Reset held two cycles with a valid bundle offered.
    b = rand_bundle();
    apply(b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    #1;
    res = 1'b1;
    in_valid = 1'b0;
    mon_en = 1'b1;

    // ADD immediate with negative offset.
    b = zero_bundle();
    b.op = 3'd0; b.op1 = 32'd5; b.ext = 32'hFFFF_FFFE; b.alusrc = 1; b.regdest = 0;
    b.rd1 = 5'd7; b.regwrite = 1;
    cyc(b, 1, 0, 1);

    // BEQ taken, then not taken.
    b = zero_bundle();
    b.op = 3'd1; b.op1 = 32'h10; b.op2 = 32'h10; b.branch = 1; b.next = 32'h100; b.ext = 32'd4;
    cyc(b, 1, 0, 1);
    b.op2 = 32'h11;
    cyc(b, 1, 0, 1);

    // Stall three cycles while inputs keep changing, then accept a new bundle.
    cyc(rand_bundle(), 1, 0, 1);
    repeat (3) cyc(rand_bundle(), 1, 0, 0);
    cyc(rand_bundle(), 1, 0, 1);

    // Flushed store becomes a bubble.
    b = zero_bundle();
    b.memwrite = 1; b.alusrc = 1;
    cyc(b, 1, 1, 1);
    cyc(b, 0, 0, 1);

    // SLT signed, SLL by 31, NOR of zeros.
    b = zero_bundle();
    b.op = 3'd4; b.op1 = 32'hFFFF_FFFF; b.op2 = 32'd1; b.regwrite = 1;
    cyc(b, 1, 0, 1);
    b.op = 3'd6; b.op1 = 32'd1; b.op2 = 32'd31;
    cyc(b, 1, 0, 1);
    b.op = 3'd7; b.op1 = 32'd0; b.op2 = 32'd0; b.regdest = 1; b.rd2 = 5'd0;
    cyc(b, 1, 0, 1);

    // Random traffic with back-pressure, idle cycles and flushes.
    for (int i = 0; i < 1500; i++) begin
      cyc(rand_bundle(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 9) < 7));
    end

    // Reset during a stall wins over the held entry.
    cyc(rand_bundle(), 1, 0, 1);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    res = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("reset_stall");
    sb.delete();
    #1;
    res = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cyc(rand_bundle(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)));
    end

    // Drain and confirm nothing is left outstanding.
    repeat (3) cyc(rand_bundle(), 0, 0, 1);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
